// File: rtl/pipe_pkg.sv
// Shared fetch-pipe types: opcode/width constants and the prefetch queue entry.
package pipe_pkg;
  localparam int IW = 8;
  localparam int AW = 8;
  localparam logic [1:0] OP_JUMP = 2'b11;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } fifo_entry_t;

  function automatic logic is_jump(input logic [IW-1:0] instr);
    return instr[IW-1 -: 2] == OP_JUMP;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular queue with flush; head read combinationally from storage.
module fetch_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        push_i,
  input  fifo_entry_t push_dat_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [CW-1:0] count_o,
  output fifo_entry_t head_o
);
  fifo_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is legal only when the head leaves the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher feeding a credit-checked queue, with redirect flush.
// Optional jump predecode on returned data is enabled by FETCH_JUMP_PREDECODE_EN.
module fetch_prefetch_queue
  import pipe_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = 8'h00
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          inflight_vld_q, inflight_epoch_q, epoch_q, epoch_d;
  logic [AW-1:0] inflight_addr_q;
  logic          accept, push, pop, issue, jump_take;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occ_after;
  fifo_entry_t   head, push_dat;

  assign pop       = out_valid && out_ready;
  assign accept    = inflight_vld_q && (inflight_epoch_q == epoch_q) && !reset && !redirect_valid;
  assign push      = accept && !fifo_full;
  assign push_dat  = '{instr: imem_rdata, pc: inflight_addr_q};
  assign epoch_d   = epoch_q ^ redirect_valid;

  // Credit: queued + in-flight, less the head leaving now, must leave room for one more.
  assign occ_after = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_vld_q} - {{CW{1'b0}}, pop};
  assign issue     = !reset && !redirect_valid && (occ_after < DEPTH_W);

`ifdef FETCH_JUMP_PREDECODE_EN
  assign jump_take = accept && is_jump(imem_rdata);
`else
  assign jump_take = 1'b0;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (issue)          fetch_pc_d = fetch_pc_q + 1'b1;
    if (jump_take)      fetch_pc_d = {inflight_addr_q[AW-1 -: 2], imem_rdata[5:0]};
    if (redirect_valid) fetch_pc_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q       <= RESET_PC;
      inflight_vld_q   <= 1'b0;
      inflight_addr_q  <= '0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      // A fetch issued alongside a taken jump is on the wrong path.
      inflight_vld_q   <= issue && !jump_take;
      inflight_addr_q  <= fetch_pc_q;
      inflight_epoch_q <= epoch_d;
      epoch_q          <= epoch_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk),
    .reset_i   (reset),
    .push_i    (push),
    .push_dat_i(push_dat),
    .pop_i     (pop),
    .flush_i   (redirect_valid),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count),
    .head_o    (head)
  );

  assign imem_en   = issue;
  assign imem_addr = fetch_pc_q;
  assign out_valid = !fifo_empty && !reset;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc    : '0;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed + random bench for fetch_prefetch_queue against a program-order delivery model.
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic clk = 1'b0;
  logic reset, imem_en, out_valid, out_ready, redirect_valid;
  logic [7:0] imem_addr, imem_rdata, out_instr, out_pc, redirect_pc;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  logic [7:0] mem [256];
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  int tests = 0, fails = 0;
  int outst = 0, fetch_cnt = 0;
  logic [7:0] exp_pc, prev_pc, prev_instr;
  bit prev_stall = 0;
  logic [7:0] dq[$];
  logic s_en, s_valid;
  logic [7:0] s_addr, s_pc;

  // Program order: next pc is sequential, or the jump target when predecode is on.
  function automatic logic [7:0] next_pc(input logic [7:0] pc, input logic [7:0] instr);
`ifdef FETCH_JUMP_PREDECODE_EN
    if (instr[7:6] == 2'b11) return {pc[7:6], instr[5:0]};
`endif
    return pc + 8'd1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit xfer;
    @(negedge clk);
    s_en = imem_en; s_addr = imem_addr; s_valid = out_valid; s_pc = out_pc;
    if (reset) begin
      chk("rst_imem_en", imem_en, 8'd0);
      chk("rst_out_valid", out_valid, 8'd0);
      chk("rst_out_pc", out_pc, 8'd0);
      chk("rst_out_instr", out_instr, 8'd0);
      exp_pc = RESET_PC; prev_stall = 0; outst = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 8'd1);
        chk("stall_pc", out_pc, prev_pc);
        chk("stall_instr", out_instr, prev_instr);
      end
      if (redirect_valid) chk("redirect_no_fetch", imem_en, 8'd0);
      xfer = out_valid && out_ready;
      if (xfer) begin
        chk("out_pc", out_pc, exp_pc);
        chk("out_instr", out_instr, mem[exp_pc]);
        dq.push_back(out_pc);
        exp_pc = next_pc(exp_pc, mem[exp_pc]);
      end
`ifndef FETCH_JUMP_PREDECODE_EN
      if (imem_en) chk("no_overflow", 8'((outst - int'(xfer)) < DEPTH), 8'd1);
      if (!redirect_valid && outst < DEPTH) chk("issue_when_room", imem_en, 8'd1);
`endif
      if (imem_en) fetch_cnt++;
      outst += int'(imem_en) - int'(xfer);
      if (redirect_valid) begin
        exp_pc = redirect_pc; outst = 0; prev_stall = 0;
      end else begin
        prev_stall = out_valid && !out_ready;
        prev_pc = out_pc; prev_instr = out_instr;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] p;
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    foreach (mem[i]) mem[i] = 8'($urandom_range(0, 191));
    mem[0] = 8'h19; mem[1] = 8'h49; mem[2] = 8'h0B; mem[3] = 8'h0C;
`ifdef FETCH_JUMP_PREDECODE_EN
    mem[3] = 8'hC5;
`endif

    // Reset, then streaming startup with out_ready held high
    repeat (3) cyc();
    reset = 1'b0; out_ready = 1'b1; dq.delete();
    cyc();
    chk("first_fetch_en", s_en, 8'd1);
    chk("first_fetch_addr", s_addr, RESET_PC);
    cyc();
    chk("latency_c1_valid", s_valid, 8'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("startup_valid", s_valid, 8'd1);
      chk("startup_pc", s_pc, 8'(k));
    end
    repeat (6) cyc();
    chk("startup_count", 8'(dq.size() >= 5), 8'd1);
    p = 8'h00;
    for (int k = 0; k < 5 && k < dq.size(); k++) begin
      chk("startup_seq", dq[k], p);
      p = next_pc(p, mem[p]);
    end

    // Stalled decode: exactly DEPTH fetches, then ordered release
    reset = 1'b1; out_ready = 1'b0; cyc();
    reset = 1'b0; fetch_cnt = 0;
    repeat (10) cyc();
    chk("stall_fetch_cnt", 8'(fetch_cnt), 8'(DEPTH));
    chk("stall_no_fetch", s_en, 8'd0);
    chk("stall_head_pc", s_pc, 8'h00);
    dq.delete(); out_ready = 1'b1;
    repeat (14) cyc();
    chk("release_count", 8'(dq.size() >= 8), 8'd1);
    p = 8'h00;
    for (int k = 0; k < 8 && k < dq.size(); k++) begin
      chk("release_seq", dq[k], p);
      p = next_pc(p, mem[p]);
    end

    // Redirect with 3 queued and one in flight
    reset = 1'b1; out_ready = 1'b0; cyc();
    reset = 1'b0;
    repeat (4) cyc();
    redirect_valid = 1'b1; redirect_pc = 8'h20; cyc();
    redirect_valid = 1'b0; cyc();
    chk("redir_valid_low", s_valid, 8'd0);
    chk("redir_fetch_en", s_en, 8'd1);
    chk("redir_fetch_addr", s_addr, 8'h20);
    out_ready = 1'b1; dq.delete();
    repeat (6) cyc();
    chk("redir_delivered", 8'(dq.size() >= 1), 8'd1);
    if (dq.size() >= 1) chk("redir_first_pc", dq[0], 8'h20);

    // PC wrap FF -> 00
    redirect_valid = 1'b1; redirect_pc = 8'hFE; cyc();
    redirect_valid = 1'b0; dq.delete();
    repeat (8) cyc();
    chk("wrap_count", 8'(dq.size() >= 4), 8'd1);
    p = 8'hFE;
    for (int k = 0; k < 4 && k < dq.size(); k++) begin
      chk("wrap_seq", dq[k], p);
      p = p + 8'd1;
    end

    // Back-to-back redirects: last one wins
    redirect_valid = 1'b1; redirect_pc = 8'h40; cyc();
    redirect_pc = 8'h80; cyc();
    redirect_valid = 1'b0; dq.delete();
    repeat (6) cyc();
    chk("b2b_delivered", 8'(dq.size() >= 1), 8'd1);
    if (dq.size() >= 1) chk("b2b_first_pc", dq[0], 8'h80);

    // One-cycle reset with 3 queued and a fetch in flight
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 8'h10; cyc();
    redirect_valid = 1'b0;
    repeat (4) cyc();
    reset = 1'b1; cyc();
    reset = 1'b0; cyc();
    chk("reset_flush_valid", s_valid, 8'd0);
    out_ready = 1'b1; dq.delete();
    repeat (6) cyc();
    chk("reset_restart_cnt", 8'(dq.size() >= 1), 8'd1);
    if (dq.size() >= 1) chk("reset_restart_pc", dq[0], RESET_PC);

    // Random traffic against the model
    repeat (800) begin
      reset          = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 8'($urandom);
      out_ready      = ($urandom_range(0, 9) < 7);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
